// File: rtl/adder_axis_pkg.sv
// Shared definitions for the add/subtract join unit: mode encoding and a
// width-generic reference of the arithmetic for reuse outside the datapath.
package adder_axis_pkg;

    typedef enum logic {
        MODE_ADD = 1'b0,
        MODE_SUB = 1'b1
    } mode_e;

    localparam int unsigned MAX_W = 64;

    // Returns {cb, res, ovf}: cb is carry (add) or borrow (sub), res is the
    // w-bit result zero-extended to MAX_W bits, ovf is signed overflow.
    function automatic logic [MAX_W+1:0] add_sub_ovf(
        input logic [MAX_W-1:0] a,
        input logic [MAX_W-1:0] b,
        input logic             mode,
        input int unsigned      w
    );
        logic [MAX_W:0]   mask;
        logic [MAX_W:0]   am;
        logic [MAX_W:0]   bm;
        logic [MAX_W:0]   full;
        logic [MAX_W-1:0] res;
        logic             cb;
        logic             ovf;
        mask = ({{MAX_W{1'b0}}, 1'b1} << w) - 1'b1;
        am   = {1'b0, a} & mask;
        bm   = {1'b0, b} & mask;
        full = (mode == MODE_SUB) ? (am - bm) : (am + bm);
        cb   = full[w];
        res  = full[MAX_W-1:0] & mask[MAX_W-1:0];
        if (mode == MODE_SUB) begin
            ovf = (am[w-1] != bm[w-1]) && (res[w-1] != am[w-1]);
        end else begin
            ovf = (am[w-1] == bm[w-1]) && (res[w-1] != am[w-1]);
        end
        return {cb, res, ovf};
    endfunction

endpackage

// File: rtl/adder_axis_join_slot.sv
// Single-entry operand holding slot: accepts one word, holds it until the
// consumer fires, and can be refilled on the same edge it is consumed.
module operand_slot
    import adder_axis_pkg::*;
#(
    parameter int unsigned DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          consume,
    output logic          full,
    output logic [DW-1:0] data
);

    logic          full_q;
    logic          full_d;
    logic [DW-1:0] data_q;
    logic [DW-1:0] data_d;
    logic          accept;

    assign in_ready = !rst && (!full_q || consume);
    assign accept   = in_valid && in_ready;
    assign full     = full_q;
    assign data     = data_q;

    // Next slot state: consume empties, a same-edge accept refills
    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (consume) begin
            full_d = 1'b0;
        end
        if (accept) begin
            full_d = 1'b1;
            data_d = in_data;
        end
    end

    // Slot registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

endmodule

// File: rtl/adder_axis_join.sv
// Joins operand A and operand B (+mode) streams and produces registered
// A+B / A-B with carry/borrow and signed overflow, one result per cycle.
module adder_axis_join
    import adder_axis_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] s_a_tdata,
    input  logic         s_a_tvalid,
    output logic         s_a_tready,
    input  logic [W-1:0] s_b_tdata,
    input  logic         s_b_tuser,
    input  logic         s_b_tvalid,
    output logic         s_b_tready,
    output logic [W:0]   m_result_tdata,
    output logic         m_result_tuser,
    output logic         m_tvalid,
    input  logic         m_tready
);

    logic         a_full;
    logic         b_full;
    logic [W-1:0] a_data;
    logic [W:0]   b_slot;
    logic         fire;
    mode_e        mode;
    logic [W:0]   arith;
    logic         arith_ovf;

    logic [W:0]   m_data_q;
    logic [W:0]   m_data_d;
    logic         m_ovf_q;
    logic         m_ovf_d;
    logic         m_valid_q;
    logic         m_valid_d;

    assign fire = a_full && b_full && (!m_valid_q || m_tready);

    operand_slot #(.DW(W)) u_slot_a (
        .clk      (clk),
        .rst      (rst),
        .in_data  (s_a_tdata),
        .in_valid (s_a_tvalid),
        .in_ready (s_a_tready),
        .consume  (fire),
        .full     (a_full),
        .data     (a_data)
    );

    operand_slot #(.DW(W + 1)) u_slot_b (
        .clk      (clk),
        .rst      (rst),
        .in_data  ({s_b_tuser, s_b_tdata}),
        .in_valid (s_b_tvalid),
        .in_ready (s_b_tready),
        .consume  (fire),
        .full     (b_full),
        .data     (b_slot)
    );

    // Add or subtract the held operands, with signed-overflow detection
    always_comb begin
        mode = mode_e'(b_slot[W]);
        if (mode == MODE_SUB) begin
            arith     = {1'b0, a_data} - {1'b0, b_slot[W-1:0]};
            arith_ovf = (a_data[W-1] != b_slot[W-1]) && (arith[W-1] != a_data[W-1]);
        end else begin
            arith     = {1'b0, a_data} + {1'b0, b_slot[W-1:0]};
            arith_ovf = (a_data[W-1] == b_slot[W-1]) && (arith[W-1] != a_data[W-1]);
        end
    end

    // Output register: load on fire, drop valid on a bare handshake, else hold
    always_comb begin
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_ovf_d   = m_ovf_q;
        if (fire) begin
            m_valid_d = 1'b1;
            m_data_d  = arith;
            m_ovf_d   = arith_ovf;
        end else if (m_tready) begin
            m_valid_d = 1'b0;
        end
    end

    // Output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_ovf_q   <= 1'b0;
        end else begin
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_ovf_q   <= m_ovf_d;
        end
    end

    assign m_tvalid       = m_valid_q;
    assign m_result_tdata = m_data_q;
    assign m_result_tuser = m_ovf_q;

endmodule

// File: tb/tb_adder_axis_join.sv
// Scoreboard bench for adder_axis_join (W = 8).
module tb_adder_axis_join;
    import adder_axis_pkg::*;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic [W-1:0] s_a_tdata;
    logic         s_a_tvalid;
    logic         s_a_tready;
    logic [W-1:0] s_b_tdata;
    logic         s_b_tuser;
    logic         s_b_tvalid;
    logic         s_b_tready;
    logic [W:0]   m_result_tdata;
    logic         m_result_tuser;
    logic         m_tvalid;
    logic         m_tready;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] qa[$];
    logic [8:0] qb[$];
    logic [9:0] exp_q[$];

    logic       stall_pending = 1'b0;
    logic [9:0] held;
    bit         rand_done;

    adder_axis_join #(.W(W)) dut (
        .clk            (clk),
        .rst            (rst),
        .s_a_tdata      (s_a_tdata),
        .s_a_tvalid     (s_a_tvalid),
        .s_a_tready     (s_a_tready),
        .s_b_tdata      (s_b_tdata),
        .s_b_tuser      (s_b_tuser),
        .s_b_tvalid     (s_b_tvalid),
        .s_b_tready     (s_b_tready),
        .m_result_tdata (m_result_tdata),
        .m_result_tuser (m_result_tuser),
        .m_tvalid       (m_tvalid),
        .m_tready       (m_tready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference: plain integer arithmetic on signed/unsigned interpretations.
    // Returns {ovf, carry/borrow, 8-bit result}.
    function automatic logic [9:0] model(input int a, input int b, input bit sub);
        int sa, sb, r, sr;
        bit ovf;
        int data;
        sa = (a > 127) ? a - 256 : a;
        sb = (b > 127) ? b - 256 : b;
        if (!sub) begin
            r  = a + b;
            sr = sa + sb;
            data = r;
        end else begin
            r  = a - b;
            sr = sa - sb;
            data = ((r < 0) ? 256 : 0) + ((r + 256) % 256);
        end
        ovf = (sr > 127) || (sr < -128);
        return {ovf, 9'(data)};
    endfunction

    // Monitor: records operand handshakes, pairs them, checks every result
    initial begin
        forever begin
            @(negedge clk);
            if (stall_pending) begin
                check("hold_valid", 64'(m_tvalid), 64'd1);
                check("hold_data", 64'({m_result_tuser, m_result_tdata}), 64'(held));
                stall_pending = 1'b0;
            end
            if (m_tvalid === 1'b1 && m_tready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 64'(m_result_tdata), 64'h1ff_dead);
                end else begin
                    logic [9:0] e;
                    e = exp_q.pop_front();
                    check("result_data", 64'(m_result_tdata), 64'(e[8:0]));
                    check("result_ovf", 64'(m_result_tuser), 64'(e[9]));
                end
            end else if (m_tvalid === 1'b1) begin
                stall_pending = 1'b1;
                held = {m_result_tuser, m_result_tdata};
            end
            if (rst) begin
                qa.delete();
                qb.delete();
                exp_q.delete();
                stall_pending = 1'b0;
            end else begin
                if (s_a_tvalid && s_a_tready) qa.push_back(s_a_tdata);
                if (s_b_tvalid && s_b_tready) qb.push_back({s_b_tuser, s_b_tdata});
                while (qa.size() > 0 && qb.size() > 0) begin
                    logic [7:0]   a;
                    logic [8:0]   b;
                    logic [9:0]   m;
                    logic [65:0]  r;
                    a = qa.pop_front();
                    b = qb.pop_front();
                    m = model(int'(a), int'(b[7:0]), b[8]);
                    r = add_sub_ovf(64'(a), 64'(b[7:0]), b[8], 8);
                    check("pkg_fn", 64'({r[0], r[65], r[8:1]}), 64'(m));
                    exp_q.push_back(m);
                end
            end
        end
    end

    task automatic drive_a(input int n);
        for (int i = 0; i < n; i++) begin
            int t;
            int gap;
            s_a_tvalid = 1'b1;
            s_a_tdata  = 8'($urandom);
            t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (!s_a_tready && t < 200);
            if (!s_a_tready) check("a_timeout", 64'd0, 64'd1);
            @(posedge clk); #1;
            s_a_tvalid = 1'b0;
            gap = $urandom_range(0, 2);
            repeat (gap) begin @(posedge clk); #1; end
        end
    endtask

    task automatic drive_b(input int n);
        for (int i = 0; i < n; i++) begin
            int t;
            int gap;
            s_b_tvalid = 1'b1;
            s_b_tdata  = 8'($urandom);
            s_b_tuser  = 1'($urandom);
            t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (!s_b_tready && t < 200);
            if (!s_b_tready) check("b_timeout", 64'd0, 64'd1);
            @(posedge clk); #1;
            s_b_tvalid = 1'b0;
            gap = $urandom_range(0, 2);
            repeat (gap) begin @(posedge clk); #1; end
        end
    endtask

    task automatic drain();
        int t;
        m_tready = 1'b1;
        t = 0;
        while ((exp_q.size() != 0 || m_tvalid) && t < 30) begin
            @(negedge clk);
            t++;
        end
        @(posedge clk); #1;
        check("drained", 64'(exp_q.size()), 64'd0);
    endtask

    // Drives one simultaneous pair and checks the two-edge latency and value
    task automatic pair(input logic [7:0] a, input logic [7:0] b, input bit sub,
                        input logic [8:0] exp_data, input bit exp_ovf, input string nm);
        s_a_tvalid = 1'b1; s_a_tdata = a;
        s_b_tvalid = 1'b1; s_b_tdata = b; s_b_tuser = sub;
        @(negedge clk);
        check({nm, "_ready"}, 64'({s_a_tready, s_b_tready}), 64'b11);
        @(posedge clk); #1;
        s_a_tvalid = 1'b0; s_b_tvalid = 1'b0;
        @(negedge clk);
        check({nm, "_not_yet"}, 64'(m_tvalid), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check({nm, "_valid"}, 64'(m_tvalid), 64'd1);
        check({nm, "_data"}, 64'(m_result_tdata), 64'(exp_data));
        check({nm, "_ovf"}, 64'(m_result_tuser), 64'(exp_ovf));
        @(posedge clk); #1;
    endtask

    task automatic skew(input bit a_first);
        if (a_first) begin s_a_tvalid = 1'b1; s_a_tdata = 8'h33; end
        else begin s_b_tvalid = 1'b1; s_b_tdata = 8'h11; s_b_tuser = 1'b0; end
        @(posedge clk); #1;
        s_a_tvalid = 1'b0; s_b_tvalid = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            if (c == 10) begin
                if (a_first) begin s_b_tvalid = 1'b1; s_b_tdata = 8'h11; s_b_tuser = 1'b1; end
                else begin s_a_tvalid = 1'b1; s_a_tdata = 8'h33; end
            end
            @(negedge clk);
            check("skew_wait_ready", 64'(a_first ? s_a_tready : s_b_tready), 64'd0);
            check("skew_no_out", 64'(m_tvalid), 64'd0);
            @(posedge clk); #1;
        end
        s_a_tvalid = 1'b0; s_b_tvalid = 1'b0;
        @(negedge clk);
        check("skew_fire_pending", 64'(m_tvalid), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("skew_valid", 64'(m_tvalid), 64'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        m_tready = 1'b1;
        s_a_tvalid = 1'b1; s_a_tdata = 8'h5A;
        s_b_tvalid = 1'b1; s_b_tdata = 8'h3C; s_b_tuser = 1'b0;

        // Reset sequence with valids asserted
        @(posedge clk); #1;
        repeat (3) begin
            @(negedge clk);
            check("rst_readies", 64'({s_a_tready, s_b_tready}), 64'b00);
            check("rst_valid", 64'(m_tvalid), 64'd0);
            check("rst_data", 64'({m_result_tuser, m_result_tdata}), 64'd0);
            @(posedge clk); #1;
        end
        rst = 1'b0;
        s_a_tvalid = 1'b0; s_b_tvalid = 1'b0;
        @(negedge clk);
        check("post_rst_readies", 64'({s_a_tready, s_b_tready}), 64'b11);
        repeat (3) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("no_leak_after_rst", 64'(m_tvalid), 64'd0);
        end
        @(posedge clk); #1;

        // Directed arithmetic boundaries
        pair(8'h7F, 8'h01, 1'b0, 9'h080, 1'b1, "add_ovf");
        pair(8'hFF, 8'h01, 1'b0, 9'h100, 1'b0, "add_carry");
        pair(8'h05, 8'h07, 1'b1, 9'h1FE, 1'b0, "sub_borrow");
        pair(8'h80, 8'h01, 1'b1, 9'h07F, 1'b1, "sub_ovf");
        drain();

        // Skewed arrival both ways
        skew(1'b1);
        skew(1'b0);
        drain();

        // Full back-pressure: slots fill, readies drop, release is combinational
        m_tready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            s_a_tvalid = 1'b1; s_a_tdata = 8'($urandom);
            s_b_tvalid = 1'b1; s_b_tdata = 8'($urandom); s_b_tuser = 1'($urandom);
            @(negedge clk);
            @(posedge clk); #1;
        end
        s_a_tvalid = 1'b0; s_b_tvalid = 1'b0;
        @(negedge clk);
        check("bp_readies_low", 64'({s_a_tready, s_b_tready}), 64'b00);
        check("bp_out_valid", 64'(m_tvalid), 64'd1);
        @(posedge clk); #1;
        m_tready = 1'b1;
        @(negedge clk);
        check("bp_release_readies", 64'({s_a_tready, s_b_tready}), 64'b11);
        @(posedge clk); #1;
        drain();

        // Random operand streams with random back-pressure
        rand_done = 1'b0;
        fork
            begin
                while (!rand_done) begin
                    m_tready = 1'($urandom);
                    @(posedge clk); #1;
                end
            end
        join_none
        fork
            drive_a(16);
            drive_b(16);
        join
        rand_done = 1'b1;
        @(posedge clk); #1;
        drain();

        // Full-rate stream with a one-cycle reset in the middle
        m_tready = 1'b1;
        for (int k = 0; k < 40; k++) begin
            rst = (k == 20);
            s_a_tvalid = 1'b1; s_a_tdata = 8'($urandom);
            s_b_tvalid = 1'b1; s_b_tdata = 8'($urandom); s_b_tuser = 1'($urandom);
            @(negedge clk);
            if ((k >= 2 && k < 20) || k >= 23) check("full_rate_valid", 64'(m_tvalid), 64'd1);
            if (k == 21 || k == 22) check("mid_rst_flush", 64'(m_tvalid), 64'd0);
            @(posedge clk); #1;
        end
        rst = 1'b0;
        s_a_tvalid = 1'b0; s_b_tvalid = 1'b0;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
